// File: rtl/branch_resolution_unit.sv
// Branch resolution unit: queues fetch-time predictions in order, checks them
// against execute outcomes, trains the BHT, and raises a one-cycle redirect on a miss.
module branch_resolution_unit #(
  parameter int LOWER = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             pred_valid,
  input  logic [LOWER-1:0] pred_index,
  input  logic             pred_taken,
  input  logic [31:0]      pred_alt_pc,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic             upd_en,
  output logic [LOWER-1:0] upd_addr,
  output logic             upd_taken,
  output logic [15:0]      branch_cnt,
  output logic [15:0]      mispred_cnt,
  output logic             res_error
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] RECOVER = 1'b1;

  logic [0:0]       state;
  logic [0:0]       state_next;

  logic [LOWER-1:0] idx_mem [DEPTH];
  logic             tk_mem  [DEPTH];
  logic [31:0]      alt_mem [DEPTH];

  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;

  logic             in_run;
  logic             pop;
  logic             push;
  logic             mispred;
  logic             empty_res;

  logic [LOWER-1:0] head_index;
  logic             head_taken;
  logic [31:0]      head_alt_pc;

  assign head_index  = idx_mem[rd_ptr];
  assign head_taken  = tk_mem[rd_ptr];
  assign head_alt_pc = alt_mem[rd_ptr];

  // Ready depends only on registered state, so a full queue never accepts a push
  // even when the head retires on the same edge.
  assign in_run     = (state == RUN);
  assign pred_ready = in_run && (count < CW'(DEPTH));

  assign pop       = in_run && res_valid && (count != '0);
  assign empty_res = in_run && res_valid && (count == '0);
  assign mispred   = pop && (res_taken != head_taken);

  // A push that coincides with a miss is on the wrong path and is dropped.
  assign push      = pred_valid && pred_ready && !mispred;

  // NOTE: every signal assigned in always_comb gets a default first, otherwise
  // a missed branch path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (mispred) state_next = RECOVER;
      RECOVER: state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // NOTE: the payload storage carries no reset; occupancy and pointers alone
  // decide which entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      idx_mem[wr_ptr] <= pred_index;
      tk_mem[wr_ptr]  <= pred_taken;
      alt_mem[wr_ptr] <= pred_alt_pc;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state  <= RUN;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_next;
      if (mispred) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        // Pointer arithmetic wraps naturally because DEPTH is a power of two.
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      flush       <= 1'b0;
      redirect_pc <= '0;
      upd_en      <= 1'b0;
      upd_addr    <= '0;
      upd_taken   <= 1'b0;
    end else begin
      flush  <= mispred;
      upd_en <= pop;
      if (mispred) redirect_pc <= head_alt_pc;
      if (pop) begin
        upd_addr  <= head_index;
        upd_taken <= res_taken;
      end
    end
  end

  // Statistics saturate rather than wrap so long runs never under-report.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
      res_error   <= 1'b0;
    end else begin
      if (pop && (branch_cnt != 16'hFFFF))     branch_cnt  <= branch_cnt + 16'd1;
      if (mispred && (mispred_cnt != 16'hFFFF)) mispred_cnt <= mispred_cnt + 16'd1;
      if (empty_res) res_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Self-checking bench: a queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_branch_resolution_unit;

  localparam int LOWER = 5;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             arst;
  logic             pred_valid;
  logic [LOWER-1:0] pred_index;
  logic             pred_taken;
  logic [31:0]      pred_alt_pc;
  logic             pred_ready;
  logic             res_valid;
  logic             res_taken;
  logic             flush;
  logic [31:0]      redirect_pc;
  logic             upd_en;
  logic [LOWER-1:0] upd_addr;
  logic             upd_taken;
  logic [15:0]      branch_cnt;
  logic [15:0]      mispred_cnt;
  logic             res_error;

  branch_resolution_unit #(.LOWER(LOWER), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .arst        (arst),
    .pred_valid  (pred_valid),
    .pred_index  (pred_index),
    .pred_taken  (pred_taken),
    .pred_alt_pc (pred_alt_pc),
    .pred_ready  (pred_ready),
    .res_valid   (res_valid),
    .res_taken   (res_taken),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .upd_en      (upd_en),
    .upd_addr    (upd_addr),
    .upd_taken   (upd_taken),
    .branch_cnt  (branch_cnt),
    .mispred_cnt (mispred_cnt),
    .res_error   (res_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit run_cmp  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an in-order queue of predictions and plain integer counters.
  typedef struct {
    logic [LOWER-1:0] idx;
    logic             tk;
    logic [31:0]      alt;
  } ent_t;

  ent_t             q[$];
  bit               m_recover;
  bit               m_flush;
  logic [31:0]      m_redir;
  bit               m_upd;
  logic [LOWER-1:0] m_addr;
  bit               m_updt;
  int               m_bc;
  int               m_mc;
  bit               m_err;

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      q.delete();
      m_recover = 0; m_flush = 0; m_redir = '0; m_upd = 0;
      m_addr = '0; m_updt = 0; m_bc = 0; m_mc = 0; m_err = 0;
    end else begin
      bit   ready;
      bit   miss;
      ent_t e;
      ready   = !m_recover && (q.size() < DEPTH);
      miss    = 0;
      m_upd   = 0;
      m_flush = 0;
      if (m_recover) begin
        m_recover = 0;
      end else if (res_valid) begin
        if (q.size() == 0) begin
          m_err = 1;
        end else begin
          e      = q.pop_front();
          m_upd  = 1;
          m_addr = e.idx;
          m_updt = res_taken;
          if (m_bc < 65535) m_bc++;
          if (res_taken != e.tk) begin
            miss      = 1;
            m_flush   = 1;
            m_redir   = e.alt;
            if (m_mc < 65535) m_mc++;
            q.delete();
            m_recover = 1;
          end
        end
      end
      if (pred_valid && ready && !miss) begin
        e.idx = pred_index; e.tk = pred_taken; e.alt = pred_alt_pc;
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp && !arst) begin
      check("cmp_pred_ready", 32'(pred_ready), 32'(!m_recover && (q.size() < DEPTH)));
      check("cmp_flush",      32'(flush),       32'(m_flush));
      check("cmp_redirect",   redirect_pc,      m_redir);
      check("cmp_upd_en",     32'(upd_en),      32'(m_upd));
      if (m_upd) begin
        check("cmp_upd_addr",  32'(upd_addr),  32'(m_addr));
        check("cmp_upd_taken", 32'(upd_taken), 32'(m_updt));
      end
      check("cmp_branch_cnt",  32'(branch_cnt),  32'(m_bc));
      check("cmp_mispred_cnt", 32'(mispred_cnt), 32'(m_mc));
      check("cmp_res_error",   32'(res_error),   32'(m_err));
    end
  end

  // Called at a falling edge; returns at the next falling edge with inputs idle.
  task automatic step(input bit pv, input logic [LOWER-1:0] idx, input bit tk,
                      input logic [31:0] alt, input bit rv, input bit rt);
    pred_valid = pv; pred_index = idx; pred_taken = tk; pred_alt_pc = alt;
    res_valid = rv; res_taken = rt;
    @(negedge clk);
    pred_valid = 1'b0;
    res_valid  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flush"},   32'(flush),       32'd0);
    check({tag, "_redir"},   redirect_pc,      32'd0);
    check({tag, "_upd_en"},  32'(upd_en),      32'd0);
    check({tag, "_upd_adr"}, 32'(upd_addr),    32'd0);
    check({tag, "_upd_tk"},  32'(upd_taken),   32'd0);
    check({tag, "_bcnt"},    32'(branch_cnt),  32'd0);
    check({tag, "_mcnt"},    32'(mispred_cnt), 32'd0);
    check({tag, "_err"},     32'(res_error),   32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    arst = 1'b1;
    pred_valid = 1'b0; pred_index = '0; pred_taken = 1'b0; pred_alt_pc = '0;
    res_valid = 1'b0; res_taken = 1'b0;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    arst = 1'b0;
    run_cmp = 1'b1;
    @(negedge clk);
    check("post_reset_ready", 32'(pred_ready), 32'd1);

    // Correct prediction trains the BHT, no flush.
    step(1, 5'd3, 1, 32'h100, 0, 0);
    step(0, 5'd0, 0, 32'h0, 1, 1);
    check("hit_upd_en",    32'(upd_en),     32'd1);
    check("hit_upd_addr",  32'(upd_addr),   32'd3);
    check("hit_upd_taken", 32'(upd_taken),  32'd1);
    check("hit_flush",     32'(flush),      32'd0);
    check("hit_bcnt",      32'(branch_cnt), 32'd1);

    // Misprediction of the oldest of three entries.
    step(1, 5'd7, 0, 32'h40, 0, 0);
    step(1, 5'd8, 1, 32'h80, 0, 0);
    step(1, 5'd9, 1, 32'hC0, 0, 0);
    step(0, 5'd0, 0, 32'h0, 1, 1);
    check("miss_flush",    32'(flush),       32'd1);
    check("miss_redirect", redirect_pc,      32'h40);
    check("miss_mcnt",     32'(mispred_cnt), 32'd1);
    check("miss_ready",    32'(pred_ready),  32'd0);
    check("miss_upd_addr", 32'(upd_addr),    32'd7);
    check("miss_bcnt",     32'(branch_cnt),  32'd2);
    // Recovery cycle: resolve and push are both ignored.
    step(1, 5'd20, 1, 32'h200, 1, 1);
    check("recover_flush",  32'(flush),      32'd0);
    check("recover_ready",  32'(pred_ready), 32'd1);
    check("recover_upd",    32'(upd_en),     32'd0);
    check("recover_err",    32'(res_error),  32'd0);
    check("recover_redir",  redirect_pc,     32'h40);

    // Fill to DEPTH; push into a full queue is dropped even with a same-cycle pop.
    for (int i = 0; i < 4; i++) step(1, 5'(10 + i), 1, 32'(32'h1000 + i), 0, 0);
    check("full_ready", 32'(pred_ready), 32'd0);
    step(1, 5'd14, 1, 32'h2000, 1, 1);
    check("full_pop_addr",  32'(upd_addr),   32'd10);
    check("full_pop_ready", 32'(pred_ready), 32'd1);
    step(1, 5'd15, 1, 32'h3000, 0, 0);
    check("refill_ready", 32'(pred_ready), 32'd0);
    step(0, 5'd0, 0, 32'h0, 1, 1);
    check("drain0_addr", 32'(upd_addr), 32'd11);
    step(0, 5'd0, 0, 32'h0, 1, 1);
    check("drain1_addr", 32'(upd_addr), 32'd12);
    step(0, 5'd0, 0, 32'h0, 1, 1);
    check("drain2_addr", 32'(upd_addr), 32'd13);
    step(0, 5'd0, 0, 32'h0, 1, 1);
    check("drain3_addr", 32'(upd_addr),   32'd15);
    check("drain_bcnt",  32'(branch_cnt), 32'd7);

    // Resolve with an empty queue raises a sticky error and nothing else.
    step(0, 5'd0, 0, 32'h0, 1, 0);
    check("empty_err",  32'(res_error),   32'd1);
    check("empty_upd",  32'(upd_en),      32'd0);
    check("empty_bcnt", 32'(branch_cnt),  32'd7);
    check("empty_mcnt", 32'(mispred_cnt), 32'd1);
    step(0, 5'd0, 0, 32'h0, 0, 0);
    check("empty_err_sticky", 32'(res_error), 32'd1);

    // Asynchronous reset between edges with three entries queued.
    step(1, 5'd1, 1, 32'h11, 0, 0);
    step(1, 5'd2, 1, 32'h22, 0, 0);
    step(1, 5'd3, 1, 32'h33, 0, 0);
    #2 arst = 1'b1;
    #1 check_all_zero("async_rst");
    #1 arst = 1'b0;
    @(negedge clk);
    check("async_rst_ready", 32'(pred_ready), 32'd1);
    step(0, 5'd0, 0, 32'h0, 1, 1);
    check("async_rst_discard_err", 32'(res_error),  32'd1);
    check("async_rst_discard_bc",  32'(branch_cnt), 32'd0);

    // Saturation of branch_cnt with steady push+pop at occupancy one.
    step(1, 5'd5, 1, 32'h55, 0, 0);
    for (int i = 0; i < 65536; i++) begin
      step(1, 5'd5, 1, 32'h55, 1, 1);
      if (i == 65533) check("sat_minus1", 32'(branch_cnt), 32'hFFFE);
    end
    check("sat_bcnt", 32'(branch_cnt), 32'hFFFF);
    step(1, 5'd5, 1, 32'h55, 1, 1);
    check("sat_hold",   32'(branch_cnt),  32'hFFFF);
    check("sat_upd",    32'(upd_en),      32'd1);
    check("sat_mcnt",   32'(mispred_cnt), 32'd0);

    run_cmp = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
